// File: rtl/commit_rf_tracker_if.sv
// Trace drain handshake between the commit tracker
// and an off-core debug / difftest consumer.
interface commit_rf_tracker_if #(
  parameter int RW   = 5,
  parameter int XLEN = 32
);
  logic            trace_valid;
  logic            trace_ready;
  logic [31:0]     trace_pc;
  logic [RW-1:0]   trace_wnum;
  logic [XLEN-1:0] trace_wdata;

  modport master (
    output trace_valid,
    output trace_pc,
    output trace_wnum,
    output trace_wdata,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_pc,
    input  trace_wnum,
    input  trace_wdata,
    output trace_ready
  );
endinterface

// File: rtl/commit_rf_tracker.sv
// Commit-side architectural state: shadow RF, retire counter,
// registered debug read port and a committed-write trace FIFO.
module commit_rf_tracker #(
  parameter int COMMIT_W    = 2,
  parameter int NREG        = 32,
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 8,
  localparam int RW = $clog2(NREG),
  localparam int PW = $clog2(TRACE_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [COMMIT_W-1:0]      cmt_valid,
  input  logic [COMMIT_W-1:0]      rf_wen,
  input  logic [COMMIT_W*RW-1:0]   wb_rf_wnum,
  input  logic [COMMIT_W*XLEN-1:0] wb_rf_wdata,
  input  logic [COMMIT_W*32-1:0]   wb_pc,
  output logic [NREG*XLEN-1:0]     logic_rf,
  output logic [63:0]              commit_cnt,
  input  logic                     rd_req,
  input  logic [RW-1:0]            reg_num,
  output logic [XLEN-1:0]          rf_rdata,
  output logic                     ws_valid,
  commit_rf_tracker_if.master      trace,
  output logic [CW-1:0]            trace_count,
  output logic                     trace_ovf,
  input  logic                     trace_ovf_clr
);

  typedef struct packed {
    logic [31:0]     pc;
    logic [RW-1:0]   wnum;
    logic [XLEN-1:0] wdata;
  } ent_t;

  logic [COMMIT_W-1:0] w_we;
  logic [CW-1:0]       w_n;
  logic [2:0]          w_ncmt;
  logic [PW-1:0]       w_slot [COMMIT_W];
  logic [CW-1:0]       w_space;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic [XLEN-1:0]     w_byp;
  ent_t                w_head;

  logic [XLEN-1:0]     r_rf [NREG];
  logic [63:0]         r_cnt;
  ent_t                r_mem [TRACE_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_ovf;
  logic [XLEN-1:0]     r_rdata;
  logic                r_ws_valid;

  // Effective writes, their FIFO slots in port order, retire count
  always_comb begin
    w_we   = '0;
    w_n    = '0;
    w_ncmt = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      w_slot[i] = r_wptr + w_n[PW-1:0];
      w_we[i]   = cmt_valid[i] & rf_wen[i]
                & (wb_rf_wnum[i*RW +: RW] != '0);
      if (w_we[i]) w_n = w_n + CW'(1);
      if (cmt_valid[i]) w_ncmt = w_ncmt + 3'd1;
    end
  end

  // Push is all-or-nothing against the pre-pop occupancy
  always_comb begin
    w_space = CW'(TRACE_DEPTH) - r_count;
    w_drop  = (w_n > w_space);
    w_push  = (w_n != '0) & ~w_drop;
    w_pop   = (r_count != '0) & trace.trace_ready;
  end

  // Debug read bypass: later ports override earlier ones
  always_comb begin
    w_byp = r_rf[reg_num];
    for (int i = 0; i < COMMIT_W; i++) begin
      if (w_we[i] && wb_rf_wnum[i*RW +: RW] == reg_num)
        w_byp = wb_rf_wdata[i*XLEN +: XLEN];
    end
  end

  // Shadow RF update; NBA order lets the highest port win
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < NREG; r++) r_rf[r] <= '0;
    end else begin
      for (int i = 0; i < COMMIT_W; i++) begin
        if (w_we[i])
          r_rf[wb_rf_wnum[i*RW +: RW]] <= wb_rf_wdata[i*XLEN +: XLEN];
      end
    end
  end

  // Retired instruction counter, wraps naturally
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_cnt <= '0;
    else          r_cnt <= r_cnt + 64'(w_ncmt);
  end

  // Trace storage; contents are don't-care while empty
  always_ff @(posedge aclk) begin
    if (w_push) begin
      for (int i = 0; i < COMMIT_W; i++) begin
        if (w_we[i]) begin
          r_mem[w_slot[i]].pc    <= wb_pc[i*32 +: 32];
          r_mem[w_slot[i]].wnum  <= wb_rf_wnum[i*RW +: RW];
          r_mem[w_slot[i]].wdata <= wb_rf_wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + w_n[PW-1:0];
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + (w_push ? w_n : CW'(0))
                         - (w_pop ? CW'(1) : CW'(0));
    end
  end

  // Sticky overflow; a drop beats a same-cycle clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)          r_ovf <= 1'b0;
    else if (w_drop)       r_ovf <= 1'b1;
    else if (trace_ovf_clr) r_ovf <= 1'b0;
  end

  // Registered debug read port
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdata    <= '0;
      r_ws_valid <= 1'b0;
    end else begin
      r_ws_valid <= rd_req;
      if (rd_req) r_rdata <= w_byp;
    end
  end

  // Flatten shadow RF; r0 is hard zero
  always_comb begin
    logic_rf = '0;
    for (int r = 1; r < NREG; r++)
      logic_rf[r*XLEN +: XLEN] = r_rf[r];
  end

  // Head outputs forced to zero while empty
  always_comb begin
    w_head            = r_mem[r_rptr];
    trace.trace_valid = (r_count != '0);
    trace.trace_pc    = trace.trace_valid ? w_head.pc    : '0;
    trace.trace_wnum  = trace.trace_valid ? w_head.wnum  : '0;
    trace.trace_wdata = trace.trace_valid ? w_head.wdata : '0;
  end

  assign commit_cnt  = r_cnt;
  assign rf_rdata    = r_rdata;
  assign ws_valid    = r_ws_valid;
  assign trace_count = r_count;
  assign trace_ovf   = r_ovf;

endmodule

// File: tb/tb_commit_rf_tracker.sv
// Directed self-checking bench for commit_rf_tracker
// (COMMIT_W=2, NREG=32, XLEN=32, TRACE_DEPTH=8).
module tb_commit_rf_tracker;
  logic         aclk = 1'b0;
  logic         aresetn;
  logic [1:0]   cmt_valid;
  logic [1:0]   rf_wen;
  logic [9:0]   wb_rf_wnum;
  logic [63:0]  wb_rf_wdata;
  logic [63:0]  wb_pc;
  logic [1023:0] logic_rf;
  logic [63:0]  commit_cnt;
  logic         rd_req;
  logic [4:0]   reg_num;
  logic [31:0]  rf_rdata;
  logic         ws_valid;
  logic [3:0]   trace_count;
  logic         trace_ovf;
  logic         trace_ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  commit_rf_tracker_if #(.RW(5), .XLEN(32)) trc ();

  commit_rf_tracker dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmt_valid(cmt_valid), .rf_wen(rf_wen),
    .wb_rf_wnum(wb_rf_wnum), .wb_rf_wdata(wb_rf_wdata),
    .wb_pc(wb_pc), .logic_rf(logic_rf),
    .commit_cnt(commit_cnt), .rd_req(rd_req),
    .reg_num(reg_num), .rf_rdata(rf_rdata),
    .ws_valid(ws_valid), .trace(trc),
    .trace_count(trace_count), .trace_ovf(trace_ovf),
    .trace_ovf_clr(trace_ovf_clr)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] rf(input int r);
    return logic_rf[r*32 +: 32];
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    cmt_valid = '0; rf_wen = '0;
    wb_rf_wnum = '0; wb_rf_wdata = '0; wb_pc = '0;
    rd_req = 1'b0; reg_num = '0; trace_ovf_clr = 1'b0;
  endtask

  task automatic drv(input logic [1:0] v, input logic [1:0] w,
                     input logic [4:0] n0, input logic [31:0] d0,
                     input logic [31:0] p0,
                     input logic [4:0] n1, input logic [31:0] d1,
                     input logic [31:0] p1);
    cmt_valid = v; rf_wen = w;
    wb_rf_wnum = {n1, n0};
    wb_rf_wdata = {d1, d0};
    wb_pc = {p1, p0};
  endtask

  task automatic test_reset();
    aresetn = 1'b0; idle(); trc.trace_ready = 1'b0;
    step(); step();
    n_cmp++; if (logic_rf !== '0) begin n_err++; $display("FAIL rst_rf got %h want 0", logic_rf[255:0]); end
    n_cmp++; if (commit_cnt !== 64'd0) begin n_err++; $display("FAIL rst_cnt got %h want 0", commit_cnt); end
    n_cmp++; if (ws_valid !== 1'b0 || rf_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rd got %b/%h want 0/0", ws_valid, rf_rdata); end
    n_cmp++; if (trc.trace_valid !== 1'b0 || trace_count !== 4'd0) begin n_err++; $display("FAIL rst_fifo got %b/%0d want 0/0", trc.trace_valid, trace_count); end
    n_cmp++; if (trc.trace_pc !== 32'd0 || trc.trace_wdata !== 32'd0 || trc.trace_wnum !== 5'd0) begin n_err++; $display("FAIL rst_head got %h/%h want 0/0", trc.trace_pc, trc.trace_wdata); end
    n_cmp++; if (trace_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", trace_ovf); end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    drv(2'b01, 2'b01, 5'd5, 32'h1234, 32'h1c000000, 5'd0, 32'd0, 32'd0);
    step(); idle();
    n_cmp++; if (rf(5) !== 32'h1234) begin n_err++; $display("FAIL sw_rf5 got %h want 1234", rf(5)); end
    n_cmp++; if (commit_cnt !== 64'd1) begin n_err++; $display("FAIL sw_cnt got %0d want 1", commit_cnt); end
    n_cmp++; if (trc.trace_valid !== 1'b1 || trace_count !== 4'd1) begin n_err++; $display("FAIL sw_tv got %b/%0d want 1/1", trc.trace_valid, trace_count); end
    n_cmp++; if ({trc.trace_pc, trc.trace_wnum, trc.trace_wdata} !== {32'h1c000000, 5'd5, 32'h1234}) begin n_err++; $display("FAIL sw_head got %h/%0d/%h want 1c000000/5/1234", trc.trace_pc, trc.trace_wnum, trc.trace_wdata); end
    trc.trace_ready = 1'b1;
    step();
    trc.trace_ready = 1'b0;
    n_cmp++; if (trc.trace_valid !== 1'b0 || trace_count !== 4'd0) begin n_err++; $display("FAIL sw_pop got %b/%0d want 0/0", trc.trace_valid, trace_count); end
  endtask

  task automatic test_collision();
    drv(2'b11, 2'b11, 5'd7, 32'hAAAA, 32'h100, 5'd7, 32'hBBBB, 32'h104);
    rd_req = 1'b1; reg_num = 5'd7;
    step(); idle();
    n_cmp++; if (ws_valid !== 1'b1 || rf_rdata !== 32'hBBBB) begin n_err++; $display("FAIL col_rd got %b/%h want 1/bbbb", ws_valid, rf_rdata); end
    n_cmp++; if (rf(7) !== 32'hBBBB) begin n_err++; $display("FAIL col_rf7 got %h want bbbb", rf(7)); end
    n_cmp++; if (commit_cnt !== 64'd3) begin n_err++; $display("FAIL col_cnt got %0d want 3", commit_cnt); end
    n_cmp++; if (trace_count !== 4'd2 || trc.trace_pc !== 32'h100 || trc.trace_wdata !== 32'hAAAA) begin n_err++; $display("FAIL col_h0 got %0d/%h/%h want 2/100/aaaa", trace_count, trc.trace_pc, trc.trace_wdata); end
    trc.trace_ready = 1'b1;
    step();
    n_cmp++; if (ws_valid !== 1'b0 || rf_rdata !== 32'hBBBB) begin n_err++; $display("FAIL col_hold got %b/%h want 0/bbbb", ws_valid, rf_rdata); end
    n_cmp++; if (trace_count !== 4'd1 || trc.trace_pc !== 32'h104 || trc.trace_wdata !== 32'hBBBB) begin n_err++; $display("FAIL col_h1 got %0d/%h/%h want 1/104/bbbb", trace_count, trc.trace_pc, trc.trace_wdata); end
    step();
    trc.trace_ready = 1'b0;
    n_cmp++; if (trace_count !== 4'd0) begin n_err++; $display("FAIL col_drain got %0d want 0", trace_count); end
  endtask

  task automatic test_r0_invalid();
    drv(2'b10, 2'b11, 5'd3, 32'h55, 32'h200, 5'd0, 32'hFFFF, 32'h204);
    rd_req = 1'b1; reg_num = 5'd0;
    step(); idle();
    n_cmp++; if (rf(0) !== 32'd0 || rf(3) !== 32'd0) begin n_err++; $display("FAIL r0_rf got %h/%h want 0/0", rf(0), rf(3)); end
    n_cmp++; if (trace_count !== 4'd0 || trc.trace_valid !== 1'b0) begin n_err++; $display("FAIL r0_push got %0d want 0", trace_count); end
    n_cmp++; if (commit_cnt !== 64'd4) begin n_err++; $display("FAIL r0_cnt got %0d want 4", commit_cnt); end
    n_cmp++; if (rf_rdata !== 32'd0 || ws_valid !== 1'b1) begin n_err++; $display("FAIL r0_rd got %b/%h want 1/0", ws_valid, rf_rdata); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) begin
      drv(2'b11, 2'b11,
          5'(2*k+1), 32'h100 + 32'(2*k+1), 32'h2000 + 32'((2*k+1)*4),
          5'(2*k+2), 32'h100 + 32'(2*k+2), 32'h2000 + 32'((2*k+2)*4));
      step();
    end
    drv(2'b01, 2'b01, 5'd7, 32'h107, 32'h201c, 5'd0, 32'd0, 32'd0);
    step(); idle();
    n_cmp++; if (trace_count !== 4'd7 || trace_ovf !== 1'b0) begin n_err++; $display("FAIL ov_fill got %0d/%b want 7/0", trace_count, trace_ovf); end
    n_cmp++; if (commit_cnt !== 64'd11) begin n_err++; $display("FAIL ov_cnt got %0d want 11", commit_cnt); end
    drv(2'b11, 2'b11, 5'd8, 32'h108, 32'h2020, 5'd9, 32'h109, 32'h2024);
    step(); idle();
    n_cmp++; if (trace_count !== 4'd7 || trace_ovf !== 1'b1) begin n_err++; $display("FAIL ov_drop got %0d/%b want 7/1", trace_count, trace_ovf); end
    n_cmp++; if (rf(8) !== 32'h108 || rf(9) !== 32'h109 || commit_cnt !== 64'd13) begin n_err++; $display("FAIL ov_rf got %h/%h/%0d want 108/109/13", rf(8), rf(9), commit_cnt); end
    n_cmp++; if (trc.trace_wnum !== 5'd1 || trc.trace_pc !== 32'h2004 || trc.trace_wdata !== 32'h101) begin n_err++; $display("FAIL ov_stable got %0d/%h/%h want 1/2004/101", trc.trace_wnum, trc.trace_pc, trc.trace_wdata); end
    trace_ovf_clr = 1'b1;
    step(); idle();
    n_cmp++; if (trace_ovf !== 1'b0) begin n_err++; $display("FAIL ov_clr got %b want 0", trace_ovf); end
    drv(2'b01, 2'b01, 5'd10, 32'h10A, 32'h2028, 5'd0, 32'd0, 32'd0);
    step(); idle();
    n_cmp++; if (trace_count !== 4'd8 || trace_ovf !== 1'b0) begin n_err++; $display("FAIL ov_lastfit got %0d/%b want 8/0", trace_count, trace_ovf); end
  endtask

  task automatic test_full_pop();
    drv(2'b01, 2'b01, 5'd11, 32'h10B, 32'h202c, 5'd0, 32'd0, 32'd0);
    trc.trace_ready = 1'b1; trace_ovf_clr = 1'b1;
    step(); idle();
    trc.trace_ready = 1'b0;
    n_cmp++; if (trace_count !== 4'd7 || trace_ovf !== 1'b1) begin n_err++; $display("FAIL fp_cnt got %0d/%b want 7/1", trace_count, trace_ovf); end
    n_cmp++; if (trc.trace_wnum !== 5'd2 || commit_cnt !== 64'd15) begin n_err++; $display("FAIL fp_head got %0d/%0d want 2/15", trc.trace_wnum, commit_cnt); end
    trace_ovf_clr = 1'b1;
    step(); idle();
    trc.trace_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    n_cmp++; if (trace_count !== 4'd1 || trc.trace_wnum !== 5'd10 || trc.trace_pc !== 32'h2028) begin n_err++; $display("FAIL fp_tail got %0d/%0d/%h want 1/10/2028", trace_count, trc.trace_wnum, trc.trace_pc); end
    step();
    trc.trace_ready = 1'b0;
    n_cmp++; if (trace_count !== 4'd0 || trc.trace_valid !== 1'b0 || trace_ovf !== 1'b0) begin n_err++; $display("FAIL fp_empty got %0d/%b/%b want 0/0/0", trace_count, trc.trace_valid, trace_ovf); end
  endtask

  task automatic test_cnt_wrap();
    force dut.r_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.r_cnt;
    n_cmp++; if (commit_cnt !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL wr_pre got %h want fffffffffffffffe", commit_cnt); end
    drv(2'b11, 2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    step(); idle();
    n_cmp++; if (commit_cnt !== 64'd0) begin n_err++; $display("FAIL wr_zero got %h want 0", commit_cnt); end
    force dut.r_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_cnt;
    drv(2'b11, 2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    step(); idle();
    n_cmp++; if (commit_cnt !== 64'd1) begin n_err++; $display("FAIL wr_one got %h want 1", commit_cnt); end
  endtask

  task automatic test_reset_mid();
    drv(2'b11, 2'b11, 5'd12, 32'hC0C0, 32'h3000, 5'd13, 32'hD0D0, 32'h3004);
    step();
    n_cmp++; if (trace_count !== 4'd2 || rf(13) !== 32'hD0D0) begin n_err++; $display("FAIL rm_pre got %0d/%h want 2/d0d0", trace_count, rf(13)); end
    drv(2'b11, 2'b11, 5'd14, 32'hE0E0, 32'h3008, 5'd15, 32'hF0F0, 32'h300c);
    rd_req = 1'b1; reg_num = 5'd13;
    #2;
    aresetn = 1'b0;
    #1;
    n_cmp++; if (logic_rf !== '0 || commit_cnt !== 64'd0) begin n_err++; $display("FAIL rm_state got %h/%0d want 0/0", rf(13), commit_cnt); end
    n_cmp++; if (trace_count !== 4'd0 || trc.trace_valid !== 1'b0 || trc.trace_pc !== 32'd0) begin n_err++; $display("FAIL rm_fifo got %0d/%b/%h want 0/0/0", trace_count, trc.trace_valid, trc.trace_pc); end
    n_cmp++; if (ws_valid !== 1'b0 || rf_rdata !== 32'd0 || trace_ovf !== 1'b0) begin n_err++; $display("FAIL rm_rd got %b/%h/%b want 0/0/0", ws_valid, rf_rdata, trace_ovf); end
    step();
    idle();
    aresetn = 1'b1;
    step();
    n_cmp++; if (trace_count !== 4'd0 || commit_cnt !== 64'd0 || ws_valid !== 1'b0) begin n_err++; $display("FAIL rm_post got %0d/%0d/%b want 0/0/0", trace_count, commit_cnt, ws_valid); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_collision();
    test_r0_invalid();
    test_overflow();
    test_full_pop();
    test_cnt_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
